// File: rtl/uart_term_writer_if.sv
// Byte input and charbuf write-port bundle for uart_term_writer.
interface uart_term_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;

  modport master (
    output in_data, in_valid,
    input  vram_addr, vram_data, vram_we
  );

  modport slave (
    input  in_data, in_valid,
    output vram_addr, vram_data, vram_we
  );
endinterface

// File: rtl/uart_term_writer.sv
// Terminal front end: turns received bytes into charbuf writes at a cursor, with line/screen clears.
// Define ANSI_ESC_EN to consume ESC/CSI sequences (ESC[2J, ESC[H, ESC[..m).
module uart_term_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic               clk,
  input  logic               rst,
  uart_term_writer_if.slave  term,
  output logic [6:0]         cursor_col,
  output logic [4:0]         cursor_row,
  output logic               busy,
  output logic               overrun
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

`ifdef ANSI_ESC_EN
  typedef enum logic [2:0] {IDLE, CLR_SCR, CLR_LINE, ESC, CSI} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLR_SCR, CLR_LINE} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  sw_row_q, sw_row_d;
  logic [6:0]  sw_col_q, sw_col_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ovr_q, ovr_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        busy_w;
  logic        take;
  logic [7:0]  cur_byte;
  logic [4:0]  row_adv;

  assign busy_w   = (state_q == CLR_SCR) || (state_q == CLR_LINE);
  // The held byte always goes first so bytes are processed in arrival order.
  assign take     = !busy_w && (hold_full_q || term.in_valid);
  assign cur_byte = hold_full_q ? hold_q : term.in_data;
  assign row_adv  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

`ifdef ANSI_ESC_EN
  logic [6:0]  param_q, param_d;
  logic [10:0] csi_acc;
  logic [6:0]  csi_sat;

  assign csi_acc = ({4'b0, param_q} * 11'd10) + {7'b0, cur_byte[3:0]};
  assign csi_sat = (csi_acc > 11'd99) ? 7'd99 : csi_acc[6:0];
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    sw_row_d    = sw_row_q;
    sw_col_d    = sw_col_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef ANSI_ESC_EN
    param_d     = param_q;
`endif

    if (busy_w) begin
      if (term.in_valid) begin
        if (!hold_full_q) begin
          hold_d      = term.in_data;
          hold_full_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end else if (hold_full_q) begin
      if (term.in_valid) hold_d = term.in_data;
      else               hold_full_d = 1'b0;
    end

    unique case (state_q)
      CLR_SCR: begin
        we_d   = 1'b1;
        addr_d = {sw_row_q, sw_col_q};
        data_d = BLANK;
        if (sw_col_q == COL_LAST) begin
          sw_col_d = '0;
          if (sw_row_q == ROW_LAST) begin
            sw_row_d = '0;
            state_d  = IDLE;
          end else begin
            sw_row_d = sw_row_q + 5'd1;
          end
        end else begin
          sw_col_d = sw_col_q + 7'd1;
        end
      end

      CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = {sw_row_q, sw_col_q};
        data_d = BLANK;
        if (sw_col_q == COL_LAST) begin
          sw_col_d = '0;
          state_d  = IDLE;
        end else begin
          sw_col_d = sw_col_q + 7'd1;
        end
      end

      IDLE: begin
        if (take) begin
          if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            data_d = cur_byte;
            if (col_q == COL_LAST) begin
              col_d    = '0;
              row_d    = row_adv;
              sw_row_d = row_adv;
              sw_col_d = '0;
              state_d  = CLR_LINE;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (cur_byte)
              8'h0D: col_d = '0;
              8'h0A: begin
                row_d    = row_adv;
                sw_row_d = row_adv;
                sw_col_d = '0;
                state_d  = CLR_LINE;
              end
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d  = col_q - 7'd1;
                  we_d   = 1'b1;
                  addr_d = {row_q, col_q - 7'd1};
                  data_d = BLANK;
                end
              end
              8'h0C: begin
                row_d    = '0;
                col_d    = '0;
                sw_row_d = '0;
                sw_col_d = '0;
                state_d  = CLR_SCR;
              end
`ifdef ANSI_ESC_EN
              8'h1B: state_d = ESC;
`endif
              default: ;
            endcase
          end
        end
      end

`ifdef ANSI_ESC_EN
      ESC: begin
        if (take) begin
          param_d = '0;
          state_d = (cur_byte == 8'h5B) ? CSI : IDLE;
        end
      end

      CSI: begin
        if (take) begin
          if (cur_byte >= 8'h30 && cur_byte <= 8'h39) begin
            param_d = csi_sat;
          end else if (cur_byte == 8'h3B) begin
            param_d = '0;
          end else if (cur_byte < 8'h30 || cur_byte > 8'h3F) begin
            // Final byte or junk: either way the sequence ends here.
            state_d = IDLE;
            if (cur_byte == 8'h4A && param_q == 7'd2) begin
              row_d    = '0;
              col_d    = '0;
              sw_row_d = '0;
              sw_col_d = '0;
              state_d  = CLR_SCR;
            end else if (cur_byte == 8'h48) begin
              row_d = '0;
              col_d = '0;
            end
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLR_SCR;
      row_q       <= '0;
      col_q       <= '0;
      sw_row_q    <= '0;
      sw_col_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= BLANK;
`ifdef ANSI_ESC_EN
      param_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sw_row_q    <= sw_row_d;
      sw_col_q    <= sw_col_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef ANSI_ESC_EN
      param_q     <= param_d;
`endif
    end
  end

  assign term.vram_we   = we_q;
  assign term.vram_addr = addr_q;
  assign term.vram_data = data_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign busy           = busy_w;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_term_writer.sv
// Scoreboard bench for uart_term_writer: expected vram writes queued at stimulus time, checked by a monitor.
module tb_uart_term_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_term_writer_if term();
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       overrun;

  uart_term_writer #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk        (clk),
    .rst        (rst),
    .term       (term),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overrun    (overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  // Every vram write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && term.vram_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL vram_write: got addr=%h data=%h, required no write", term.vram_addr, term.vram_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({term.vram_addr, term.vram_data} !== mon_exp) begin
          miscompares++;
          $display("FAIL vram_write: got addr=%h data=%h, required addr=%h data=%h",
                   term.vram_addr, term.vram_data, mon_exp[19:8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [4:0] r, input logic [6:0] c, input logic [7:0] d);
    exp_q.push_back({r, c, d});
  endtask

  task automatic push_blank_row(input logic [4:0] r);
    for (int c = 0; c < 80; c++) push(r, 7'(c), 8'h20);
  endtask

  task automatic push_blank_screen();
    for (int r = 0; r < 30; r++) push_blank_row(5'(r));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    term.in_data  = b;
    term.in_valid = 1'b1;
    @(negedge clk);
    term.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int gaps = 0;
    term.in_data  = 8'h51;
    term.in_valid = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (term.vram_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b, required 0", term.vram_we); end
    vectors++; if (term.vram_addr !== 12'h000) begin miscompares++; $display("FAIL rst_addr: got %h, required 000", term.vram_addr); end
    vectors++; if (term.vram_data !== 8'h20) begin miscompares++; $display("FAIL rst_data: got %h, required 20", term.vram_data); end
    vectors++; if ({cursor_row, cursor_col} !== 12'h000) begin miscompares++; $display("FAIL rst_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b, required 1", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
    term.in_valid = 1'b0;
    push_blank_screen();
    rst = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (term.vram_we !== 1'b1) gaps++;
    end
    vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL clr_scr_consecutive: got %0d gap cycles, required 0", gaps); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_scr_busy_fall: got %b, required 0", busy); end
    repeat (3) @(negedge clk);
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL reset_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_print_wrap();
    for (int i = 0; i < 80; i++) begin
      push(5'd0, 7'(i), 8'h41);
      send_byte(8'h41);
    end
    vectors++; if ({busy, cursor_row, cursor_col} !== {1'b1, 5'd1, 7'd0}) begin
      miscompares++; $display("FAIL wrap_cursor: got busy=%b (%0d,%0d), required busy=1 (1,0)", busy, cursor_row, cursor_col);
    end
    push_blank_row(5'd1);
    push(5'd1, 7'd0, 8'h41);
    send_byte(8'h41);
    wait_idle();
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if ({cursor_row, cursor_col} !== {5'd1, 7'd1}) begin miscompares++; $display("FAIL wrap_final: got (%0d,%0d), required (1,1)", cursor_row, cursor_col); end
  endtask

  task automatic test_control();
    send_byte(8'h0D);
    vectors++; if (cursor_col !== 7'd0) begin miscompares++; $display("FAIL cr_col: got %0d, required 0", cursor_col); end
    push(5'd1, 7'd0, 8'h41); send_byte(8'h41);
    push(5'd1, 7'd1, 8'h42); send_byte(8'h42);
    push(5'd1, 7'd1, 8'h20); send_byte(8'h08);
    repeat (2) @(negedge clk);
    vectors++; if (cursor_col !== 7'd1) begin miscompares++; $display("FAIL bs_col: got %0d, required 1", cursor_col); end
    send_byte(8'h0D);
    send_byte(8'h08);
    send_byte(8'h07);
    repeat (3) @(negedge clk);
    vectors++; if ({cursor_row, cursor_col} !== {5'd1, 7'd0}) begin miscompares++; $display("FAIL bs_col0: got (%0d,%0d), required (1,0)", cursor_row, cursor_col); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL control_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_bottom_wrap();
    for (int r = 2; r < 30; r++) begin
      push_blank_row(5'(r));
      send_byte(8'h0A);
      wait_idle();
    end
    vectors++; if (cursor_row !== 5'd29) begin miscompares++; $display("FAIL lf_row29: got %0d, required 29", cursor_row); end
    push_blank_row(5'd0);
    send_byte(8'h0A);
    vectors++; if ({busy, cursor_row} !== {1'b1, 5'd0}) begin miscompares++; $display("FAIL lf_bottom: got busy=%b row=%0d, required busy=1 row=0", busy, cursor_row); end
    wait_idle();
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL bottom_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (cursor_col !== 7'd0) begin miscompares++; $display("FAIL lf_col: got %0d, required 0", cursor_col); end
  endtask

  task automatic test_back_to_back();
    push(5'd0, 7'd0, 8'h78);
    push(5'd0, 7'd1, 8'h79);
    push(5'd0, 7'd2, 8'h7A);
    @(negedge clk);
    term.in_data = 8'h78; term.in_valid = 1'b1;
    @(negedge clk);
    term.in_data = 8'h79;
    @(negedge clk);
    term.in_data = 8'h7A;
    @(negedge clk);
    term.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if ({cursor_row, cursor_col} !== {5'd0, 7'd3}) begin miscompares++; $display("FAIL b2b_cursor: got (%0d,%0d), required (0,3)", cursor_row, cursor_col); end
  endtask

  task automatic test_escape();
`ifdef ANSI_ESC_EN
    push(5'd0, 7'd3, 8'h48);
    push(5'd0, 7'd4, 8'h69);
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h33); send_byte(8'h31); send_byte(8'h6D);
    send_byte(8'h48); send_byte(8'h69);
    repeat (3) @(negedge clk);
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL esc_sgr_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (cursor_col !== 7'd5) begin miscompares++; $display("FAIL esc_sgr_col: got %0d, required 5", cursor_col); end
    push_blank_screen();
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h32); send_byte(8'h4A);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL esc_clr_busy: got %b, required 1", busy); end
    wait_idle();
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL esc_clr_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if ({cursor_row, cursor_col} !== 12'h000) begin miscompares++; $display("FAIL esc_clr_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col); end
`else
    push(5'd0, 7'd3, 8'h5B);
    push(5'd0, 7'd4, 8'h33);
    push(5'd0, 7'd5, 8'h31);
    push(5'd0, 7'd6, 8'h6D);
    send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h33); send_byte(8'h31); send_byte(8'h6D);
    repeat (3) @(negedge clk);
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL esc_plain_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (cursor_col !== 7'd7) begin miscompares++; $display("FAIL esc_plain_col: got %0d, required 7", cursor_col); end
`endif
  endtask

  task automatic test_overrun();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_pre: got %b, required 0", overrun); end
    push_blank_screen();
    send_byte(8'h0C);
    vectors++; if ({busy, cursor_row, cursor_col} !== {1'b1, 12'h000}) begin
      miscompares++; $display("FAIL ff_enter: got busy=%b (%0d,%0d), required busy=1 (0,0)", busy, cursor_row, cursor_col);
    end
    push(5'd0, 7'd0, 8'h58);
    send_byte(8'h58);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_one_held: got %b, required 0", overrun); end
    send_byte(8'h59);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    wait_idle();
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL overrun_drain: got %0d pending, required 0", exp_q.size()); end
    vectors++; if ({overrun, cursor_row, cursor_col} !== {1'b1, 5'd0, 7'd1}) begin
      miscompares++; $display("FAIL overrun_final: got ovr=%b (%0d,%0d), required ovr=1 (0,1)", overrun, cursor_row, cursor_col);
    end
  endtask

  initial begin
    term.in_data  = 8'h00;
    term.in_valid = 1'b0;
    test_reset();
    test_print_wrap();
    test_control();
    test_bottom_wrap();
    test_back_to_back();
    test_escape();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
